// File: rtl/blake2s_pkg.sv
// rtl/blake2s_pkg.sv - shared constants and FSM state type for the BLAKE2s block scheduler
package blake2s_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int KK_MAX      = 32;
    localparam int NN_MAX      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_KEY_PAD,
        ST_MSG,
        ST_MSG_PAD,
        ST_WAIT_HASH
    } state_t;

endpackage

// File: rtl/blake2s_block_cnt.sv
// rtl/blake2s_block_cnt.sv - byte-in-block counter and remaining-message-byte counter
module blake2s_block_cnt
    import blake2s_pkg::*;
#(
    parameter int LL_W = 64
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            clr,
    input  logic [LL_W-1:0] load_val,
    input  logic            step,
    input  logic            dec,
    output logic [5:0]      idx,
    output logic            wrap,
    output logic            rem_next_zero,
    output logic            rem_next_le_blk
);

    logic [LL_W-1:0] rem;
    logic [LL_W-1:0] rem_next;

    // Flags look at the post-decrement count so the FSM can decide on the accepting cycle.
    assign rem_next        = dec ? rem - LL_W'(1) : rem;
    assign wrap            = step && (idx == 6'd63);
    assign rem_next_zero   = (rem_next == '0);
    assign rem_next_le_blk = (rem_next <= LL_W'(BLOCK_BYTES));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx <= 6'd0;
            rem <= '0;
        end else if (clr) begin
            idx <= 6'd0;
            rem <= load_val;
        end else begin
            if (step) begin
                idx <= idx + 6'd1;
            end
            rem <= rem_next;
        end
    end

endmodule

// File: rtl/blake2s_block_sched.sv
// rtl/blake2s_block_sched.sv - slices a key+message byte stream into padded 64-byte BLAKE2s blocks
module blake2s_block_sched
    import blake2s_pkg::*;
#(
    parameter int LL_W = 64
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start_i,
    input  logic [7:0]      kk_i,
    input  logic [7:0]      nn_i,
    input  logic [LL_W-1:0] ll_i,
    input  logic            in_valid_i,
    input  logic [7:0]      in_data_i,
    output logic            in_ready_o,
    input  logic            core_ready_i,
    input  logic            core_finished_i,
    output logic [7:0]      kk_o,
    output logic [7:0]      nn_o,
    output logic [LL_W-1:0] ll_o,
    output logic            data_v_o,
    output logic [7:0]      data_o,
    output logic [5:0]      data_idx_o,
    output logic            block_first_o,
    output logic            block_last_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    state_t     state;
    logic [5:0] idx;
    logic       wrap;
    logic       rem_next_zero;
    logic       rem_next_le_blk;
    logic       first_q;
    logic       last_q;
    logic       acc;
    logic       pad_emit;
    logic       emit;
    logic       msg_acc;
    logic       start_ok;
    logic       start_bad;
    logic       clr;

    assign in_ready_o = ((state == ST_KEY) || (state == ST_MSG)) && core_ready_i;
    assign acc        = in_valid_i && in_ready_o;
    assign pad_emit   = ((state == ST_KEY_PAD) || (state == ST_MSG_PAD)) && core_ready_i;
    assign emit       = acc || pad_emit;
    assign msg_acc    = acc && (state == ST_MSG);
    // done_o high means the previous job just closed; a start in that cycle is dropped.
    assign start_ok   = (state == ST_IDLE) && start_i && !done_o;
    assign start_bad  = (kk_i > 8'(KK_MAX)) || (nn_i == 8'd0) || (nn_i > 8'(NN_MAX));
    assign clr        = start_ok && !start_bad;

    blake2s_block_cnt #(.LL_W(LL_W)) u_cnt (
        .clk             (clk),
        .nreset          (nreset),
        .clr             (clr),
        .load_val        (ll_i),
        .step            (emit),
        .dec             (msg_acc),
        .idx             (idx),
        .wrap            (wrap),
        .rem_next_zero   (rem_next_zero),
        .rem_next_le_blk (rem_next_le_blk)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= ST_IDLE;
            kk_o          <= 8'd0;
            nn_o          <= 8'd0;
            ll_o          <= '0;
            data_v_o      <= 1'b0;
            data_o        <= 8'd0;
            data_idx_o    <= 6'd0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            data_v_o <= emit;
            done_o   <= 1'b0;
            if (emit) begin
                data_o        <= acc ? in_data_i : 8'h00;
                data_idx_o    <= idx;
                block_first_o <= first_q;
                block_last_o  <= last_q;
                // Flags for the next block are fixed at the boundary from what remains.
                if (wrap) begin
                    first_q <= 1'b0;
                    last_q  <= rem_next_le_blk;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok && start_bad) begin
                        err_o <= 1'b1;
                    end else if (clr) begin
                        err_o   <= 1'b0;
                        kk_o    <= kk_i;
                        nn_o    <= nn_i;
                        ll_o    <= ll_i;
                        busy_o  <= 1'b1;
                        first_q <= 1'b1;
                        last_q  <= (kk_i != 8'd0) ? (ll_i == '0) : (ll_i <= LL_W'(BLOCK_BYTES));
                        if (kk_i != 8'd0)     state <= ST_KEY;
                        else if (ll_i != '0)  state <= ST_MSG;
                        else                  state <= ST_MSG_PAD;
                    end
                end
                ST_KEY: begin
                    if (acc && ({2'b00, idx} == kk_o - 8'd1)) state <= ST_KEY_PAD;
                end
                ST_KEY_PAD: begin
                    if (pad_emit && wrap) state <= (ll_o != '0) ? ST_MSG : ST_WAIT_HASH;
                end
                ST_MSG: begin
                    if (msg_acc && rem_next_zero) state <= wrap ? ST_WAIT_HASH : ST_MSG_PAD;
                end
                ST_MSG_PAD: begin
                    if (pad_emit && wrap) state <= ST_WAIT_HASH;
                end
                ST_WAIT_HASH: begin
                    if (core_finished_i) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/blake2s_block_sched.md
Name: blake2s_block_sched

Overview:
- Sequences one BLAKE2s hash job into the blake2s_hash256 core.
- Latches the job parameters (kk, nn, ll) on a start pulse and accepts a byte stream (key bytes first, then message bytes) over a valid/ready handshake.
- Slices the stream into 64-byte blocks, zero-pads the key block and the final block, and drives data_idx, block_first and block_last.
- Sits between io_intf and blake2s_hash256, in place of io_intf's direct data path.

Parameters:
- BLOCK_BYTES, 64, bytes per compression block; fixed by BLAKE2s, not for override.
- LL_W, 64, width of the message-length field.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; latches kk_i, nn_i, ll_i
- kk_i  in  8  key length in bytes, 0..32
- nn_i  in  8  digest length in bytes, 1..32
- ll_i  in  LL_W  message length in bytes
- in_valid_i  in  1  input byte valid
- in_data_i  in  8  input byte
- in_ready_o  out  1  scheduler accepts in_data_i this cycle
- core_ready_i  in  1  core can absorb a byte presented on the next cycle
- core_finished_i  in  1  core finished_o (hash complete)
- kk_o / nn_o / ll_o  out  8 / 8 / LL_W  latched job parameters to the core
- data_v_o  out  1  byte valid to the core
- data_o  out  8  byte to the core
- data_idx_o  out  6  byte index within the current block
- block_first_o  out  1  current block is the first block of the job
- block_last_o  out  1  current block is the last block of the job
- busy_o  out  1  a job is in progress
- done_o  out  1  one-cycle pulse when the job completes
- err_o  out  1  sticky: last start was rejected

Behaviour:
- Reset: on nreset low, asynchronously, every output is 0 and the FSM is in IDLE. This holds mid-job; any partial block is abandoned.
- FSM states: IDLE, KEY, KEY_PAD, MSG, MSG_PAD, WAIT_HASH.
- IDLE:
  - start_i with kk>32, nn==0 or nn>32 sets err_o and stays in IDLE.
  - A valid start_i clears err_o, latches the parameters and sets busy_o.
  - Next state is KEY if kk>0, else MSG if ll>0, else MSG_PAD (empty job: one all-zero block).
- start_i while busy_o=1 is ignored.
- in_ready_o = (state is KEY or MSG) && core_ready_i. This is combinational; it is the only combinational output.
- Byte handshake: an accepted byte (in_valid_i && in_ready_o) appears on data_o with data_v_o=1 one cycle later. data_idx_o is the registered byte counter.
- Pad states:
  - Each cycle with core_ready_i=1, emit one data_v_o=1 byte of 0x00.
  - data_v_o is never asserted unless core_ready_i was high the previous cycle.
- Block counter: 6-bit, increments on each emitted byte, wraps 63 -> 0. The wrap marks the block boundary.
- KEY: after kk accepted bytes, go to KEY_PAD if kk<64 (always the case). At the boundary, go to MSG if ll>0, else WAIT_HASH.
- MSG:
  - A 64-bit remaining-byte counter decrements per accepted byte.
  - At remaining==0: if data_idx wrapped exactly, go to WAIT_HASH; else go to MSG_PAD, which pads to the boundary and then goes to WAIT_HASH.
- block_first_o: set for every byte of block 0 of the job; cleared at the first boundary.
- block_last_o:
  - Set for every byte of the final block.
  - Computed at block start: the key block with ll==0, or a message block with remaining ≤ 64, or the empty-job block.
- Both flags are stable for the whole block.
- WAIT_HASH: on core_finished_i, pulse done_o, clear busy_o and return to IDLE.
- Total blocks = (kk>0) + ceil(ll/64), minimum 1.
- Stall: core_ready_i low freezes all counters and the FSM; no bytes are lost or duplicated.
- Simultaneous events:
  - start_i in the same cycle as done_o is ignored.
  - in_valid_i outside KEY/MSG is ignored (in_ready_o=0).

Decomposition:
- Package blake2s_pkg holds:
  - BLOCK_BYTES = 64, KK_MAX = 32, NN_MAX = 32.
  - The FSM state typedef.
- Sub-module blake2s_block_cnt: the 6-bit block byte counter plus the 64-bit remaining counter, with wrap and zero flags.

Test Plan:
- kk=0, nn=32, ll=64, core_ready_i=1 -> 64 bytes, idx 0..63, first=last=1, no pad; done_o after core_finished_i.
- kk=0, ll=65 -> block 0 is 64 data bytes with first=1, last=0. Block 1 is 1 data byte plus 63 zeros, with first=0, last=1.
- kk=32, ll=0 -> one block: 32 key bytes then 32 zeros, first=last=1; in_ready_o=0 during pad.
- kk=0, ll=0 -> 64 zero bytes, first=last=1, in_ready_o never asserted.
- ll=100 with core_ready_i toggled 0/1 every 3 cycles -> emitted byte stream identical to the unstalled run; data_v_o only after a core_ready_i=1 cycle.
- nn=0 start -> err_o=1, busy_o=0. Then a valid start, then nreset pulse mid-block -> all outputs 0 asynchronously; a new job runs correctly.
